// File: rtl/ysyx_22040895_wb_arbiter_pkg.sv
// Shared constants for the write-back arbiter: source indices and count.
// Also supplies the regfile bus-width macros when the core's defines are absent.
`ifndef RegBus
`define RegBus 63:0
`endif
`ifndef RegAddrBus
`define RegAddrBus 4:0
`endif

package ysyx_22040895_wb_arbiter_pkg;

  localparam int         NSRC    = 3;
  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_LSU = 2'd1;
  localparam logic [1:0] SRC_MDU = 2'd2;

  // Encodes a one-hot grant as a source index; an empty grant maps to SRC_ALU.
  function automatic logic [1:0] onehot_to_idx(input logic [NSRC-1:0] oh);
    logic [1:0] idx;
    idx = SRC_ALU;
    if (oh[SRC_LSU]) idx = SRC_LSU;
    if (oh[SRC_MDU]) idx = SRC_MDU;
    return idx;
  endfunction

endpackage

// File: rtl/ysyx_22040895_rr_pick3.sv
// Combinational 3-way round-robin picker: the search starts one past `last`
// and wraps, returning a one-hot grant (all zero when nothing requests).
module ysyx_22040895_rr_pick3
  import ysyx_22040895_wb_arbiter_pkg::*;
(
  input  logic [NSRC-1:0] req,
  input  logic [1:0]      last,
  output logic [NSRC-1:0] gnt
);

  always_comb begin
    gnt = '0;
    case (last)
      SRC_ALU: begin
        if      (req[SRC_LSU]) gnt[SRC_LSU] = 1'b1;
        else if (req[SRC_MDU]) gnt[SRC_MDU] = 1'b1;
        else if (req[SRC_ALU]) gnt[SRC_ALU] = 1'b1;
      end
      SRC_LSU: begin
        if      (req[SRC_MDU]) gnt[SRC_MDU] = 1'b1;
        else if (req[SRC_ALU]) gnt[SRC_ALU] = 1'b1;
        else if (req[SRC_LSU]) gnt[SRC_LSU] = 1'b1;
      end
      // last == MDU (and the unused encoding 3) restart the search at the ALU.
      default: begin
        if      (req[SRC_ALU]) gnt[SRC_ALU] = 1'b1;
        else if (req[SRC_LSU]) gnt[SRC_LSU] = 1'b1;
        else if (req[SRC_MDU]) gnt[SRC_MDU] = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_22040895_wb_arbiter.sv
// Write-back arbiter: grants one of ALU/LSU/MDU per cycle into a registered
// regfile write stage and forwards that in-flight write to both read ports.
// Define YSYX_22040895_WB_RR_EN for round-robin; otherwise fixed priority ALU > LSU > MDU.
//
// Handshake: a source transfers when valid_i & ready_o; ready_o is combinational,
// at most one is high, never without its valid, and never while rst is high.
module ysyx_22040895_wb_arbiter
  import ysyx_22040895_wb_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_valid_i,
  input  logic               lsu_valid_i,
  input  logic               mdu_valid_i,
  output logic               alu_ready_o,
  output logic               lsu_ready_o,
  output logic               mdu_ready_o,
  input  logic [`RegAddrBus] alu_waddr_i,
  input  logic [`RegAddrBus] lsu_waddr_i,
  input  logic [`RegAddrBus] mdu_waddr_i,
  input  logic [`RegBus]     alu_wdata_i,
  input  logic [`RegBus]     lsu_wdata_i,
  input  logic [`RegBus]     mdu_wdata_i,
  output logic               we_o,
  output logic [`RegAddrBus] waddr_o,
  output logic [`RegBus]     wdata_o,
  input  logic [`RegAddrBus] raddr1_i,
  input  logic [`RegAddrBus] raddr2_i,
  output logic               fwd1_o,
  output logic               fwd2_o,
  output logic [`RegBus]     fwd_data_o,
  output logic [1:0]         last_grant_o
);

  logic [NSRC-1:0]   w_req;
  logic [NSRC-1:0]   w_gnt;
  logic [NSRC-1:0]   w_ready;
  logic              w_xfer;
  logic [1:0]        w_idx;
  logic [`RegAddrBus] w_waddr;
  logic [`RegBus]     w_wdata;

  logic              r_we;
  logic [`RegAddrBus] r_waddr;
  logic [`RegBus]     r_wdata;
  logic [1:0]        r_last_grant;

  assign w_req = {mdu_valid_i, lsu_valid_i, alu_valid_i};

`ifdef YSYX_22040895_WB_RR_EN
  ysyx_22040895_rr_pick3 u_pick (
    .req  (w_req),
    .last (r_last_grant),
    .gnt  (w_gnt)
  );
`else
  always_comb begin
    w_gnt = '0;
    if      (w_req[SRC_ALU]) w_gnt[SRC_ALU] = 1'b1;
    else if (w_req[SRC_LSU]) w_gnt[SRC_LSU] = 1'b1;
    else if (w_req[SRC_MDU]) w_gnt[SRC_MDU] = 1'b1;
  end
`endif

  // Pending requests are not acknowledged while reset is held.
  assign w_ready     = rst ? '0 : w_gnt;
  assign w_xfer      = |w_ready;
  assign alu_ready_o = w_ready[SRC_ALU];
  assign lsu_ready_o = w_ready[SRC_LSU];
  assign mdu_ready_o = w_ready[SRC_MDU];

  assign w_idx = onehot_to_idx(w_gnt);

  always_comb begin
    w_waddr = alu_waddr_i;
    w_wdata = alu_wdata_i;
    case (w_idx)
      SRC_LSU: begin
        w_waddr = lsu_waddr_i;
        w_wdata = lsu_wdata_i;
      end
      SRC_MDU: begin
        w_waddr = mdu_waddr_i;
        w_wdata = mdu_wdata_i;
      end
      default: begin
        w_waddr = alu_waddr_i;
        w_wdata = alu_wdata_i;
      end
    endcase
  end

  // x0 writes are accepted and captured but never enable the regfile.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_last_grant <= SRC_MDU;
    end else if (w_xfer) begin
      r_we         <= (w_waddr != '0);
      r_waddr      <= w_waddr;
      r_wdata      <= w_wdata;
      r_last_grant <= w_idx;
    end else begin
      r_we         <= 1'b0;
    end
  end

  assign we_o         = r_we;
  assign waddr_o      = r_waddr;
  assign wdata_o      = r_wdata;
  assign fwd_data_o   = r_wdata;
  assign fwd1_o       = r_we & (r_waddr == raddr1_i) & (raddr1_i != '0);
  assign fwd2_o       = r_we & (r_waddr == raddr2_i) & (raddr2_i != '0);
  assign last_grant_o = r_last_grant;

endmodule

// File: tb/tb_ysyx_22040895_wb_arbiter.sv
// Directed bench for ysyx_22040895_wb_arbiter: reset, single source, x0 write,
// forwarding, back-to-back same destination, mid-stream reset and contention.
module tb_ysyx_22040895_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid_i, lsu_valid_i, mdu_valid_i;
  logic        alu_ready_o, lsu_ready_o, mdu_ready_o;
  logic [4:0]  alu_waddr_i, lsu_waddr_i, mdu_waddr_i;
  logic [63:0] alu_wdata_i, lsu_wdata_i, mdu_wdata_i;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [63:0] wdata_o;
  logic [4:0]  raddr1_i, raddr2_i;
  logic        fwd1_o, fwd2_o;
  logic [63:0] fwd_data_o;
  logic [1:0]  last_grant_o;

  int n_checks = 0;
  int n_pass   = 0;

  ysyx_22040895_wb_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid_i  (alu_valid_i),
    .lsu_valid_i  (lsu_valid_i),
    .mdu_valid_i  (mdu_valid_i),
    .alu_ready_o  (alu_ready_o),
    .lsu_ready_o  (lsu_ready_o),
    .mdu_ready_o  (mdu_ready_o),
    .alu_waddr_i  (alu_waddr_i),
    .lsu_waddr_i  (lsu_waddr_i),
    .mdu_waddr_i  (mdu_waddr_i),
    .alu_wdata_i  (alu_wdata_i),
    .lsu_wdata_i  (lsu_wdata_i),
    .mdu_wdata_i  (mdu_wdata_i),
    .we_o         (we_o),
    .waddr_o      (waddr_o),
    .wdata_o      (wdata_o),
    .raddr1_i     (raddr1_i),
    .raddr2_i     (raddr2_i),
    .fwd1_o       (fwd1_o),
    .fwd2_o       (fwd2_o),
    .fwd_data_o   (fwd_data_o),
    .last_grant_o (last_grant_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic logic [2:0] rdy_vec();
    return {mdu_ready_o, lsu_ready_o, alu_ready_o};
  endfunction

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_srcs();
    alu_valid_i = 1'b0;
    lsu_valid_i = 1'b0;
    mdu_valid_i = 1'b0;
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] a, input logic [63:0] d);
    alu_valid_i = v; alu_waddr_i = a; alu_wdata_i = d;
  endtask

  task automatic drive_lsu(input logic v, input logic [4:0] a, input logic [63:0] d);
    lsu_valid_i = v; lsu_waddr_i = a; lsu_wdata_i = d;
  endtask

  task automatic drive_mdu(input logic v, input logic [4:0] a, input logic [63:0] d);
    mdu_valid_i = v; mdu_waddr_i = a; mdu_wdata_i = d;
  endtask

  logic [2:0] exp_gnt[6];
  logic [4:0] exp_addr;

  initial begin
`ifdef YSYX_22040895_WB_RR_EN
    exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`else
    exp_gnt = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`endif
    rst = 1'b1;
    idle_srcs();
    drive_alu(1'b1, 5'd5, 64'h5);
    drive_lsu(1'b0, 5'd0, 64'h0);
    drive_mdu(1'b0, 5'd0, 64'h0);
    raddr1_i = 5'd0;
    raddr2_i = 5'd0;

    // Reset state, with a request pending that must not be acknowledged
    #3;
    check("rst_we", we_o, 0);
    check("rst_waddr", waddr_o, 0);
    check("rst_wdata", wdata_o, 0);
    check("rst_fwd1", fwd1_o, 0);
    check("rst_fwd2", fwd2_o, 0);
    check("rst_fwd_data", fwd_data_o, 0);
    check("rst_ready", rdy_vec(), 3'b000);
    check("rst_last_grant", last_grant_o, 2);
    idle_srcs();
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Single ALU source
    drive_alu(1'b1, 5'd5, 64'hDEAD_BEEF);
    #1 check("single_ready", rdy_vec(), 3'b001);
    tick();
    idle_srcs();
    check("single_we", we_o, 1);
    check("single_waddr", waddr_o, 5);
    check("single_wdata", wdata_o, 64'hDEAD_BEEF);
    check("single_last", last_grant_o, 0);
    #1 check("single_idle_ready", rdy_vec(), 3'b000);
    tick();
    check("single_we_drop", we_o, 0);
    check("single_waddr_hold", waddr_o, 5);
    check("single_wdata_hold", wdata_o, 64'hDEAD_BEEF);

    // x0 write from LSU is accepted but discarded
    drive_lsu(1'b1, 5'd0, 64'h1234);
    #1 check("x0_ready", rdy_vec(), 3'b010);
    tick();
    idle_srcs();
    raddr1_i = 5'd0;
    #1;
    check("x0_we", we_o, 0);
    check("x0_fwd1", fwd1_o, 0);
    check("x0_last", last_grant_o, 1);
    tick();

    // Forwarding of an MDU write
    drive_mdu(1'b1, 5'd7, 64'h42);
    #1 check("fwd_ready", rdy_vec(), 3'b100);
    tick();
    idle_srcs();
    raddr1_i = 5'd7;
    raddr2_i = 5'd8;
    #1;
    check("fwd_we", we_o, 1);
    check("fwd_fwd1", fwd1_o, 1);
    check("fwd_fwd2", fwd2_o, 0);
    check("fwd_data", fwd_data_o, 64'h42);
    tick();
    check("fwd_fwd1_gone", fwd1_o, 0);

    // Back-to-back writes to x3: ALU then LSU
    raddr1_i = 5'd3;
    raddr2_i = 5'd0;
    drive_alu(1'b1, 5'd3, 64'h1);
    #1 check("b2b_alu_ready", rdy_vec(), 3'b001);
    tick();
    alu_valid_i = 1'b0;
    drive_lsu(1'b1, 5'd3, 64'h2);
    #1;
    check("b2b_lsu_ready", rdy_vec(), 3'b010);
    check("b2b_w1_waddr", waddr_o, 3);
    check("b2b_w1_wdata", wdata_o, 64'h1);
    check("b2b_w1_fwd1", fwd1_o, 1);
    check("b2b_w1_fwd_data", fwd_data_o, 64'h1);
    tick();
    idle_srcs();
    check("b2b_w2_we", we_o, 1);
    check("b2b_w2_waddr", waddr_o, 3);
    check("b2b_w2_wdata", wdata_o, 64'h2);
    check("b2b_w2_fwd1", fwd1_o, 1);
    check("b2b_w2_fwd_data", fwd_data_o, 64'h2);
    tick();

    // Reset asserted mid-stream with ALU valid and a write in flight
    raddr1_i = 5'd9;
    drive_alu(1'b1, 5'd9, 64'h99);
    tick();
    check("mrst_pre_we", we_o, 1);
    check("mrst_pre_waddr", waddr_o, 9);
    #2 rst = 1'b1;
    #1;
    check("mrst_we", we_o, 0);
    check("mrst_waddr", waddr_o, 0);
    check("mrst_wdata", wdata_o, 0);
    check("mrst_ready", rdy_vec(), 3'b000);
    check("mrst_fwd1", fwd1_o, 0);
    check("mrst_last", last_grant_o, 2);
    @(negedge clk);
    rst = 1'b0;

    // Contention: all three valid for six cycles
    drive_alu(1'b1, 5'd1, 64'h11);
    drive_lsu(1'b1, 5'd2, 64'h22);
    drive_mdu(1'b1, 5'd4, 64'h44);
    #1;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("cont_gnt%0d", k), rdy_vec(), exp_gnt[k]);
      tick();
      case (exp_gnt[k])
        3'b010:  exp_addr = 5'd2;
        3'b100:  exp_addr = 5'd4;
        default: exp_addr = 5'd1;
      endcase
      check($sformatf("cont_we%0d", k), we_o, 1);
      check($sformatf("cont_waddr%0d", k), waddr_o, exp_addr);
    end
    idle_srcs();
    #1 check("cont_idle_ready", rdy_vec(), 3'b000);
    tick();
    check("cont_idle_we", we_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
